// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the neuron parameter bank: Wishbone word offsets
// within a 16-byte neuron record, byte lane positions inside a 32-bit word,
// the slave FSM state encoding, the neuron record struct and small helpers
// for packing a record word and for the saturating reset negation.
// -----------------------------------------------------------------------------
package neuron_pkg;

    // Word offsets inside one neuron record (address bits [3:2]).
    localparam logic [1:0] WORD_WEIGHTS = 2'd0;
    localparam logic [1:0] WORD_THRESH  = 2'd1;
    localparam logic [1:0] WORD_STATE   = 2'd2;
    localparam logic [1:0] WORD_RSVD    = 2'd3;

    // LSB position of each byte lane in a 32-bit Wishbone word.
    localparam int LANE3 = 24;
    localparam int LANE2 = 16;
    localparam int LANE1 = 8;
    localparam int LANE0 = 0;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_STALL,
        ST_ACK
    } wb_state_e;

    // One neuron record. neg_reset holds the effective negative reset value
    // (derived from pos_reset / neg_reset_raw / reset_mode whenever word2 is
    // written) so a fetch is a plain copy.
    typedef struct packed {
        logic signed [7:0] w1;
        logic signed [7:0] w2;
        logic signed [7:0] w3;
        logic signed [7:0] w4;
        logic signed [7:0] leak;
        logic signed [7:0] pos_thr;
        logic signed [7:0] neg_thr;
        logic signed [7:0] voltage;
        logic signed [7:0] pos_reset;
        logic signed [7:0] neg_reset_raw;
        logic signed [7:0] neg_reset;
        logic              reset_mode;
    } neuron_params_t;

    // -v, with -128 mapping to +127 instead of wrapping back to -128.
    function automatic logic signed [7:0] sat_negate(input logic signed [7:0] v);
        if (v == 8'sh80) begin
            return 8'sh7F;
        end
        return -v;
    endfunction

    // Wishbone view of one record word; constant-zero bytes read as 0.
    function automatic logic [31:0] pack_word(input neuron_params_t r, input logic [1:0] word);
        logic [31:0] w;
        w = '0;
        case (word)
            WORD_WEIGHTS: begin
                w[LANE3 +: 8] = r.w1;
                w[LANE2 +: 8] = r.w2;
                w[LANE1 +: 8] = r.w3;
                w[LANE0 +: 8] = r.w4;
            end
            WORD_THRESH: begin
                w[LANE3 +: 8] = r.leak;
                w[LANE2 +: 8] = r.pos_thr;
                w[LANE1 +: 8] = r.neg_thr;
            end
            WORD_STATE: begin
                w[LANE3 +: 8] = r.voltage;
                w[LANE2 +: 8] = r.pos_reset;
                w[LANE1 +: 8] = r.neg_reset_raw;
                w[LANE0]      = r.reset_mode;
            end
            WORD_RSVD: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/neuron_wb_slave_fsm.sv
// -----------------------------------------------------------------------------
// neuron_wb_slave_fsm
// Address decode and control for the neuron parameter bank Wishbone slave.
// After reset it walks every record index once (INIT) so the top level can
// clear storage, then serves Wishbone accesses with a one-cycle ack. An access
// to a neuron's word2 that collides with a same-cycle voltage write-back is
// deferred by one cycle (STALL) so the Wishbone write lands last.
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/adr_i    Wishbone request qualifiers and byte address
//   vwr_en_i, vwr_idx_i      voltage write-back, used for collision detect
//   wbs_ack_o                registered one-cycle acknowledge
//   init_done_o              registered, high once clearing has finished
//   clr_en_o, clr_idx_o      clear record clr_idx_o at this edge
//   acc_en_o                 perform the Wishbone access at this edge
//   acc_idx_o, acc_word_o    decoded neuron index and word offset
// -----------------------------------------------------------------------------
module neuron_wb_slave_fsm
    import neuron_pkg::*;
#(
    parameter int          NUM_NEURONS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h3001_0000,
    parameter int          IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic             vwr_en_i,
    input  logic [IDX_W-1:0] vwr_idx_i,
    output logic             wbs_ack_o,
    output logic             init_done_o,
    output logic             clr_en_o,
    output logic [IDX_W-1:0] clr_idx_o,
    output logic             acc_en_o,
    output logic [IDX_W-1:0] acc_idx_o,
    output logic [1:0]       acc_word_o
);

    localparam logic [31:0]      SPAN     = 32'(16 * NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    wb_state_e        state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             done_q, done_d;

    logic [31:0] offset;
    logic        in_range;
    logic        req;
    logic        collide;

    always_comb begin
        offset   = wbs_adr_i - BASE_ADDR;
        in_range = (wbs_adr_i >= BASE_ADDR) && (offset < SPAN);
        req      = wbs_cyc_i && wbs_stb_i && in_range;
        acc_idx_o  = offset[IDX_W+3:4];
        acc_word_o = offset[3:2];
        collide  = vwr_en_i && (vwr_idx_i == acc_idx_o) && (acc_word_o == WORD_STATE);
    end

    // NOTE: every signal written in an always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        done_d   = done_q;
        clr_en_o = 1'b0;
        acc_en_o = 1'b0;

        case (state_q)
            ST_INIT: begin
                clr_en_o = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_IDLE: begin
                if (req) begin
                    if (collide) begin
                        state_d = ST_STALL;
                    end else begin
                        acc_en_o = 1'b1;
                        ack_d    = 1'b1;
                        state_d  = ST_ACK;
                    end
                end
            end
            ST_STALL: begin
                // The write-back finished last edge; the access goes now.
                if (req) begin
                    acc_en_o = 1'b1;
                    ack_d    = 1'b1;
                    state_d  = ST_ACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                // Never re-accept while ack is high; a held request
                // restarts from IDLE.
                state_d = ST_IDLE;
            end
        endcase

        // No storage side effects in a reset cycle.
        if (wb_rst_i) begin
            clr_en_o = 1'b0;
            acc_en_o = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its pre-edge inputs regardless of block ordering.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    assign clr_idx_o   = cnt_q;
    assign wbs_ack_o   = ack_q;
    assign init_done_o = done_q;

endmodule

// File: rtl/neuron_param_bank.sv
// -----------------------------------------------------------------------------
// neuron_param_bank
// Wishbone-mapped parameter store for NUM_NEURONS neurons. Record n word k
// lives at BASE_ADDR + 16n + 4k. Holds the record storage, the registered
// core fetch port and the voltage write-back port; control and decode are in
// neuron_wb_slave_fsm.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbs_*                       Wishbone slave (cyc/stb/we/sel/adr/dat, ack, dat_o)
//   init_done_o                 high once post-reset clearing has finished
//   rd_req_i, rd_idx_i          fetch request; record returned next cycle
//   rd_valid_o, rd_idx_o        one-cycle valid pulse and echoed index
//   *_o fetched fields          signed record fields, held until next fetch
//   vwr_en_i/idx_i/val_i        voltage write-back
// -----------------------------------------------------------------------------
module neuron_param_bank
    import neuron_pkg::*;
#(
    parameter int          NUM_NEURONS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h3001_0000,
    parameter int          IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic                    init_done_o,
    input  logic                    rd_req_i,
    input  logic [IDX_W-1:0]        rd_idx_i,
    output logic                    rd_valid_o,
    output logic [IDX_W-1:0]        rd_idx_o,
    output logic signed [7:0]       voltage_potential_o,
    output logic signed [7:0]       pos_threshold_o,
    output logic signed [7:0]       neg_threshold_o,
    output logic signed [7:0]       leak_value_o,
    output logic signed [7:0]       weight_type1_o,
    output logic signed [7:0]       weight_type2_o,
    output logic signed [7:0]       weight_type3_o,
    output logic signed [7:0]       weight_type4_o,
    output logic signed [7:0]       pos_reset_o,
    output logic signed [7:0]       neg_reset_o,
    input  logic                    vwr_en_i,
    input  logic [IDX_W-1:0]        vwr_idx_i,
    input  logic signed [7:0]       vwr_val_i
);

    logic             init_done;
    logic             clr_en;
    logic [IDX_W-1:0] clr_idx;
    logic             acc_en;
    logic [IDX_W-1:0] acc_idx;
    logic [1:0]       acc_word;

    neuron_wb_slave_fsm #(
        .NUM_NEURONS (NUM_NEURONS),
        .BASE_ADDR   (BASE_ADDR),
        .IDX_W       (IDX_W)
    ) u_fsm (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_adr_i   (wbs_adr_i),
        .vwr_en_i    (vwr_en_i),
        .vwr_idx_i   (vwr_idx_i),
        .wbs_ack_o   (wbs_ack_o),
        .init_done_o (init_done),
        .clr_en_o    (clr_en),
        .clr_idx_o   (clr_idx),
        .acc_en_o    (acc_en),
        .acc_idx_o   (acc_idx),
        .acc_word_o  (acc_word)
    );

    assign init_done_o = init_done;

    neuron_params_t rec_mem [NUM_NEURONS];

    neuron_params_t old_rec;
    neuron_params_t wr_rec;
    logic [31:0]    old_word;
    logic [31:0]    merged;
    logic           vwr_ok;
    logic           fetch_en;

    // Write-back and fetch are ignored until clearing has finished.
    assign vwr_ok   = vwr_en_i && init_done && !wb_rst_i;
    assign fetch_en = rd_req_i && init_done && !wb_rst_i;

    // Byte-masked merge of the addressed word, unpacked into record fields.
    always_comb begin
        old_rec  = rec_mem[acc_idx];
        old_word = pack_word(old_rec, acc_word);
        merged   = '0;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = wbs_sel_i[b] ? wbs_dat_i[8*b +: 8] : old_word[8*b +: 8];
        end

        wr_rec = old_rec;
        case (acc_word)
            WORD_WEIGHTS: begin
                wr_rec.w1 = merged[LANE3 +: 8];
                wr_rec.w2 = merged[LANE2 +: 8];
                wr_rec.w3 = merged[LANE1 +: 8];
                wr_rec.w4 = merged[LANE0 +: 8];
            end
            WORD_THRESH: begin
                wr_rec.leak    = merged[LANE3 +: 8];
                wr_rec.pos_thr = merged[LANE2 +: 8];
                wr_rec.neg_thr = merged[LANE1 +: 8];
            end
            WORD_STATE: begin
                wr_rec.voltage       = merged[LANE3 +: 8];
                wr_rec.pos_reset     = merged[LANE2 +: 8];
                wr_rec.neg_reset_raw = merged[LANE1 +: 8];
                wr_rec.reset_mode    = merged[LANE0];
                wr_rec.neg_reset     = merged[LANE0] ? merged[LANE1 +: 8]
                                                     : sat_negate(merged[LANE2 +: 8]);
            end
            default: ;
        endcase
    end

    // NOTE: the record array has no reset branch; INIT walks it to zero one
    // neuron per cycle, which keeps it a plain write-enabled array.
    // Statement order sets priority: a Wishbone word2 write issued in the same
    // edge as a write-back to that neuron lands last. Only the fields of the
    // addressed word are written, so a write-back to another word survives.
    always_ff @(posedge wb_clk_i) begin
        if (clr_en) begin
            rec_mem[clr_idx] <= '0;
        end
        if (vwr_ok) begin
            rec_mem[vwr_idx_i].voltage <= vwr_val_i;
        end
        if (acc_en && wbs_we_i) begin
            case (acc_word)
                WORD_WEIGHTS: begin
                    rec_mem[acc_idx].w1 <= wr_rec.w1;
                    rec_mem[acc_idx].w2 <= wr_rec.w2;
                    rec_mem[acc_idx].w3 <= wr_rec.w3;
                    rec_mem[acc_idx].w4 <= wr_rec.w4;
                end
                WORD_THRESH: begin
                    rec_mem[acc_idx].leak    <= wr_rec.leak;
                    rec_mem[acc_idx].pos_thr <= wr_rec.pos_thr;
                    rec_mem[acc_idx].neg_thr <= wr_rec.neg_thr;
                end
                WORD_STATE: begin
                    rec_mem[acc_idx].voltage       <= wr_rec.voltage;
                    rec_mem[acc_idx].pos_reset     <= wr_rec.pos_reset;
                    rec_mem[acc_idx].neg_reset_raw <= wr_rec.neg_reset_raw;
                    rec_mem[acc_idx].neg_reset     <= wr_rec.neg_reset;
                    rec_mem[acc_idx].reset_mode    <= wr_rec.reset_mode;
                end
                default: ;
            endcase
        end
    end

    // Registered Wishbone read data and fetch port.
    logic [31:0]      wb_dat_q, wb_dat_d;
    neuron_params_t   fetch_q, fetch_d;
    logic             rd_valid_q, rd_valid_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;

    always_comb begin
        wb_dat_d = wb_dat_q;
        if (acc_en && !wbs_we_i) begin
            wb_dat_d = old_word;
        end

        fetch_d    = fetch_q;
        rd_valid_d = 1'b0;
        rd_idx_d   = rd_idx_q;
        if (fetch_en) begin
            fetch_d    = rec_mem[rd_idx_i];
            rd_valid_d = 1'b1;
            rd_idx_d   = rd_idx_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_dat_q   <= '0;
            fetch_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
        end else begin
            wb_dat_q   <= wb_dat_d;
            fetch_q    <= fetch_d;
            rd_valid_q <= rd_valid_d;
            rd_idx_q   <= rd_idx_d;
        end
    end

    assign wbs_dat_o           = wb_dat_q;
    assign rd_valid_o          = rd_valid_q;
    assign rd_idx_o            = rd_idx_q;
    assign voltage_potential_o = fetch_q.voltage;
    assign pos_threshold_o     = fetch_q.pos_thr;
    assign neg_threshold_o     = fetch_q.neg_thr;
    assign leak_value_o        = fetch_q.leak;
    assign weight_type1_o      = fetch_q.w1;
    assign weight_type2_o      = fetch_q.w2;
    assign weight_type3_o      = fetch_q.w3;
    assign weight_type4_o      = fetch_q.w4;
    assign pos_reset_o         = fetch_q.pos_reset;
    assign neg_reset_o         = fetch_q.neg_reset;

endmodule

// File: tb/tb_neuron_param_bank.sv
// -----------------------------------------------------------------------------
// tb_neuron_param_bank
// Directed bench for neuron_param_bank: a table of Wishbone accesses with
// hand-computed responses, followed by hand-written fetch, write-back
// collision and mid-transaction reset sequences.
// -----------------------------------------------------------------------------
module tb_neuron_param_bank;

    localparam int          NN    = 256;
    localparam int          IDX_W = $clog2(NN);
    localparam logic [31:0] BASE  = 32'h3001_0000;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i;
    logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i, wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic              init_done_o;
    logic              rd_req_i;
    logic [IDX_W-1:0]  rd_idx_i;
    logic              rd_valid_o;
    logic [IDX_W-1:0]  rd_idx_o;
    logic signed [7:0] voltage_potential_o, pos_threshold_o, neg_threshold_o, leak_value_o;
    logic signed [7:0] weight_type1_o, weight_type2_o, weight_type3_o, weight_type4_o;
    logic signed [7:0] pos_reset_o, neg_reset_o;
    logic              vwr_en_i;
    logic [IDX_W-1:0]  vwr_idx_i;
    logic signed [7:0] vwr_val_i;

    always #5 wb_clk_i = ~wb_clk_i;

    neuron_param_bank #(
        .NUM_NEURONS (NN),
        .BASE_ADDR   (BASE)
    ) dut (
        .wb_clk_i            (wb_clk_i),
        .wb_rst_i            (wb_rst_i),
        .wbs_cyc_i           (wbs_cyc_i),
        .wbs_stb_i           (wbs_stb_i),
        .wbs_we_i            (wbs_we_i),
        .wbs_sel_i           (wbs_sel_i),
        .wbs_adr_i           (wbs_adr_i),
        .wbs_dat_i           (wbs_dat_i),
        .wbs_ack_o           (wbs_ack_o),
        .wbs_dat_o           (wbs_dat_o),
        .init_done_o         (init_done_o),
        .rd_req_i            (rd_req_i),
        .rd_idx_i            (rd_idx_i),
        .rd_valid_o          (rd_valid_o),
        .rd_idx_o            (rd_idx_o),
        .voltage_potential_o (voltage_potential_o),
        .pos_threshold_o     (pos_threshold_o),
        .neg_threshold_o     (neg_threshold_o),
        .leak_value_o        (leak_value_o),
        .weight_type1_o      (weight_type1_o),
        .weight_type2_o      (weight_type2_o),
        .weight_type3_o      (weight_type3_o),
        .weight_type4_o      (weight_type4_o),
        .pos_reset_o         (pos_reset_o),
        .neg_reset_o         (neg_reset_o),
        .vwr_en_i            (vwr_en_i),
        .vwr_idx_i           (vwr_idx_i),
        .vwr_val_i           (vwr_val_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_ack;
        logic [31:0] exp_dat;
    } wb_vec_t;

    typedef struct {
        logic             v_pre, v_at, v_post;
        logic [IDX_W-1:0] idx;
        logic [7:0]       volt, pth, nth, leak, w1, w2, w3, w4, pr, nr;
    } obs_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] adr(input int n, input int k);
        return BASE + 32'(16 * n + 4 * k);
    endfunction

    // Starts at posedge+1; optional write-back is driven for the first cycle
    // only. lat = clock edges from request to the cycle ack is seen.
    task automatic wb_access(input logic we, input logic [31:0] a, input logic [3:0] sel,
                             input logic [31:0] dat, input int budget,
                             input logic vw_en, input logic [IDX_W-1:0] vw_idx,
                             input logic [7:0] vw_val,
                             output logic acked, output logic [31:0] rdata, output int lat);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = a; wbs_sel_i = sel; wbs_dat_i = dat;
        vwr_en_i = vw_en; vwr_idx_i = vw_idx; vwr_val_i = vw_val;
        acked = 1'b0; rdata = '0; lat = 0;
        for (int i = 1; i <= budget && !acked; i++) begin
            @(posedge wb_clk_i); #1;
            vwr_en_i = 1'b0;
            lat = i;
            @(negedge wb_clk_i);
            if (wbs_ack_o) begin
                acked = 1'b1;
                rdata = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge wb_clk_i); #1;
    endtask

    task automatic fetch(input logic [IDX_W-1:0] idx, input logic vw_en,
                         input logic [IDX_W-1:0] vw_idx, input logic [7:0] vw_val,
                         output obs_t o);
        rd_req_i = 1'b1; rd_idx_i = idx;
        vwr_en_i = vw_en; vwr_idx_i = vw_idx; vwr_val_i = vw_val;
        @(negedge wb_clk_i);
        o.v_pre = rd_valid_o;
        @(posedge wb_clk_i); #1;
        rd_req_i = 1'b0; vwr_en_i = 1'b0;
        @(negedge wb_clk_i);
        o.v_at = rd_valid_o; o.idx = rd_idx_o;
        o.volt = voltage_potential_o; o.pth = pos_threshold_o; o.nth = neg_threshold_o;
        o.leak = leak_value_o; o.w1 = weight_type1_o; o.w2 = weight_type2_o;
        o.w3 = weight_type3_o; o.w4 = weight_type4_o; o.pr = pos_reset_o; o.nr = neg_reset_o;
        @(posedge wb_clk_i); #1;
        @(negedge wb_clk_i);
        o.v_post = rd_valid_o;
        @(posedge wb_clk_i); #1;
    endtask

    task automatic check_pulse(input string name, input obs_t o, input logic [IDX_W-1:0] idx);
        check({name, " valid before"}, {31'b0, o.v_pre}, 32'd0);
        check({name, " valid t+1"}, {31'b0, o.v_at}, 32'd1);
        check({name, " valid t+2"}, {31'b0, o.v_post}, 32'd0);
        check({name, " idx"}, 32'(o.idx), 32'(idx));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    wb_vec_t     vec [17];
    logic        acked;
    logic [31:0] rdata;
    int          lat;
    obs_t        o;

    initial begin
        wb_rst_i = 1'b1;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
        rd_req_i = 0; rd_idx_i = 0; vwr_en_i = 0; vwr_idx_i = 0; vwr_val_i = 0;

        vec[0]  = '{1'b1, adr(3, 0),      4'h5, 32'h0A0B_0C0D, 1'b1, 32'h0};
        vec[1]  = '{1'b0, adr(3, 0),      4'hF, 32'h0,         1'b1, 32'h000B_000D};
        vec[2]  = '{1'b1, adr(NN, 0),     4'hF, 32'h1234_5678, 1'b0, 32'h000B_000D};
        vec[3]  = '{1'b0, BASE - 32'd4,   4'hF, 32'h0,         1'b0, 32'h000B_000D};
        vec[4]  = '{1'b1, adr(7, 2),      4'hF, 32'h1080_0500, 1'b1, 32'h0};
        vec[5]  = '{1'b0, adr(7, 2),      4'hF, 32'h0,         1'b1, 32'h1080_0500};
        vec[6]  = '{1'b1, adr(4, 1),      4'hF, 32'h1122_3344, 1'b1, 32'h0};
        vec[7]  = '{1'b0, adr(4, 1),      4'hF, 32'h0,         1'b1, 32'h1122_3300};
        vec[8]  = '{1'b1, adr(4, 3),      4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0};
        vec[9]  = '{1'b0, adr(4, 3),      4'hF, 32'h0,         1'b1, 32'h0};
        vec[10] = '{1'b1, adr(4, 2),      4'h1, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vec[11] = '{1'b0, adr(4, 2),      4'hF, 32'h0,         1'b1, 32'h0000_0001};
        vec[12] = '{1'b1, adr(NN - 1, 0), 4'hF, 32'h0102_0304, 1'b1, 32'h0};
        vec[13] = '{1'b0, adr(NN - 1, 0), 4'hF, 32'h0,         1'b1, 32'h0102_0304};
        vec[14] = '{1'b0, adr(3, 0) + 3,  4'hF, 32'h0,         1'b1, 32'h000B_000D};
        vec[15] = '{1'b0, adr(NN - 1, 3), 4'hF, 32'h0,         1'b1, 32'h0};
        vec[16] = '{1'b0, adr(NN, 0),     4'hF, 32'h0,         1'b0, 32'h0};

        // Reset state.
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("rst ack", {31'b0, wbs_ack_o}, 32'd0);
        check("rst dat_o", wbs_dat_o, 32'd0);
        check("rst init_done", {31'b0, init_done_o}, 32'd0);
        check("rst rd_valid", {31'b0, rd_valid_o}, 32'd0);
        check("rst voltage", {24'b0, voltage_potential_o}, 32'd0);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;

        // Access during clearing waits until init completes.
        wb_access(1'b0, adr(5, 1), 4'hF, 32'h0, NN + 20, 1'b0, '0, 8'h0, acked, rdata, lat);
        check("init read ack", {31'b0, acked}, 32'd1);
        check("init read latency", 32'(lat), 32'(NN + 1));
        check("init read data", rdata, 32'd0);
        check("init_done high", {31'b0, init_done_o}, 32'd1);

        for (int i = 0; i < 17; i++) begin
            wb_access(vec[i].we, vec[i].adr, vec[i].sel, vec[i].dat, 4, 1'b0, '0, 8'h0,
                      acked, rdata, lat);
            check($sformatf("vec%0d ack", i), {31'b0, acked}, {31'b0, vec[i].exp_ack});
            if (vec[i].exp_ack) begin
                check($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
                if (!vec[i].we) check($sformatf("vec%0d rdata", i), rdata, vec[i].exp_dat);
            end else begin
                check($sformatf("vec%0d dat_o held", i), wbs_dat_o, vec[i].exp_dat);
            end
        end

        // Fetch port, masked weights.
        fetch(IDX_W'(3), 1'b0, '0, 8'h0, o);
        check_pulse("fetch3", o, IDX_W'(3));
        check("fetch3 w1", {24'b0, o.w1}, 32'h00);
        check("fetch3 w2", {24'b0, o.w2}, 32'h0B);
        check("fetch3 w3", {24'b0, o.w3}, 32'h00);
        check("fetch3 w4", {24'b0, o.w4}, 32'h0D);

        // Saturating negation of -128.
        fetch(IDX_W'(7), 1'b0, '0, 8'h0, o);
        check_pulse("fetch7", o, IDX_W'(7));
        check("fetch7 voltage", {24'b0, o.volt}, 32'h10);
        check("fetch7 pos_reset", {24'b0, o.pr}, 32'h80);
        check("fetch7 neg_reset sat", {24'b0, o.nr}, 32'h7F);

        fetch(IDX_W'(4), 1'b0, '0, 8'h0, o);
        check("fetch4 leak", {24'b0, o.leak}, 32'h11);
        check("fetch4 pos_thr", {24'b0, o.pth}, 32'h22);
        check("fetch4 neg_thr", {24'b0, o.nth}, 32'h33);

        // Back-to-back fetches: one record per cycle.
        rd_req_i = 1'b1; rd_idx_i = IDX_W'(3);
        @(posedge wb_clk_i); #1;
        rd_idx_i = IDX_W'(7);
        @(negedge wb_clk_i);
        check("b2b first valid", {31'b0, rd_valid_o}, 32'd1);
        check("b2b first idx", 32'(rd_idx_o), 32'd3);
        check("b2b first w2", {24'b0, weight_type2_o}, 32'h0B);
        @(posedge wb_clk_i); #1;
        rd_req_i = 1'b0;
        @(negedge wb_clk_i);
        check("b2b second valid", {31'b0, rd_valid_o}, 32'd1);
        check("b2b second idx", 32'(rd_idx_o), 32'd7);
        check("b2b second voltage", {24'b0, voltage_potential_o}, 32'h10);
        @(posedge wb_clk_i); #1;
        @(negedge wb_clk_i);
        check("b2b end valid", {31'b0, rd_valid_o}, 32'd0);
        @(posedge wb_clk_i); #1;

        // Reset mode 1 selects the raw value.
        wb_access(1'b1, adr(7, 2), 4'hF, 32'h1080_0501, 4, 1'b0, '0, 8'h0, acked, rdata, lat);
        check("mode1 write ack", {31'b0, acked}, 32'd1);
        fetch(IDX_W'(7), 1'b0, '0, 8'h0, o);
        check("mode1 neg_reset", {24'b0, o.nr}, 32'h05);

        // Write-back collides with word2 write: stall, Wishbone wins.
        wb_access(1'b1, adr(7, 2), 4'hF, 32'h2201_0100, 4, 1'b1, IDX_W'(7), 8'hFD,
                  acked, rdata, lat);
        check("stall ack", {31'b0, acked}, 32'd1);
        check("stall latency", 32'(lat), 32'd2);
        fetch(IDX_W'(7), 1'b0, '0, 8'h0, o);
        check("stall voltage", {24'b0, o.volt}, 32'h22);
        check("stall pos_reset", {24'b0, o.pr}, 32'h01);
        check("stall neg_reset", {24'b0, o.nr}, 32'hFF);

        // Write-back to a different word of the same neuron: no stall, both land.
        wb_access(1'b1, adr(7, 0), 4'hF, 32'h0102_0304, 4, 1'b1, IDX_W'(7), 8'h40,
                  acked, rdata, lat);
        check("nostall latency", 32'(lat), 32'd1);
        fetch(IDX_W'(7), 1'b0, '0, 8'h0, o);
        check("nostall voltage", {24'b0, o.volt}, 32'h40);
        check("nostall w1", {24'b0, o.w1}, 32'h01);
        check("nostall w4", {24'b0, o.w4}, 32'h04);

        // Same-cycle write-back and fetch return the old voltage.
        fetch(IDX_W'(9), 1'b1, IDX_W'(9), 8'd50, o);
        check("vwr same-cycle old", {24'b0, o.volt}, 32'h00);
        fetch(IDX_W'(9), 1'b0, '0, 8'h0, o);
        check("vwr next fetch", {24'b0, o.volt}, 32'd50);

        // Reset asserted in the ACK cycle.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = adr(3, 0); wbs_sel_i = 4'hF; wbs_dat_i = 32'h5555_5555;
        @(posedge wb_clk_i); #1;
        @(negedge wb_clk_i);
        check("pre-reset ack", {31'b0, wbs_ack_o}, 32'd1);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(negedge wb_clk_i);
        check("mid-reset ack dropped", {31'b0, wbs_ack_o}, 32'd0);
        check("mid-reset init_done", {31'b0, init_done_o}, 32'd0);
        check("mid-reset voltage", {24'b0, voltage_potential_o}, 32'd0);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        for (int i = 0; i < NN + 8 && !init_done_o; i++) begin
            @(posedge wb_clk_i); #1;
        end
        check("re-init done", {31'b0, init_done_o}, 32'd1);
        wb_access(1'b0, adr(3, 0), 4'hF, 32'h0, 4, 1'b0, '0, 8'h0, acked, rdata, lat);
        check("re-init n3w0 ack", {31'b0, acked}, 32'd1);
        check("re-init n3w0", rdata, 32'd0);
        wb_access(1'b0, adr(7, 2), 4'hF, 32'h0, 4, 1'b0, '0, 8'h0, acked, rdata, lat);
        check("re-init n7w2", rdata, 32'd0);
        wb_access(1'b0, adr(NN - 1, 0), 4'hF, 32'h0, 4, 1'b0, '0, 8'h0, acked, rdata, lat);
        check("re-init last w0", rdata, 32'd0);
        fetch(IDX_W'(9), 1'b0, '0, 8'h0, o);
        check("re-init fetch9 voltage", {24'b0, o.volt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
